uart_tx_fifo: RTL and testbench

//  Buffered UART transmitter: 8N1 serializer (8E1 with parity) behind a small sync FIFO.

---
 rtl/uart_tx_fifo.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo: buffered UART transmitter.
// A small synchronous FIFO sits in front of an 8N1 serializer. Upstream pushes
// bytes with valid/ready and only stalls when the FIFO is full.
//
// Optional feature (macro UART_TX_PARITY_EN): adds an even-parity bit after the
// data bits, which gives 8E1 framing. When the macro is undefined the framing is
// 8N1 and no parity logic is built.
//
// Parameters:
//   CLK_PER_BIT  clock cycles per UART bit (>= 2)
//   DEPTH        FIFO entries (power of 2, >= 2)
// Ports:
//   clk     in   system clock, all logic on posedge
//   rst_n   in   asynchronous active-low reset
//   tdata   in   byte to transmit
//   tvalid  in   tdata valid
//   tready  out  FIFO can accept; a push happens when tvalid && tready
//   txd     out  serial line, idle high, registered
//   busy    out  FIFO non-empty or a frame is in progress
//   count   out  FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int unsigned CLK_PER_BIT = 868,
    parameter int unsigned DEPTH       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               tdata,
    input  logic                     tvalid,
    output logic                     tready,
    output logic                     txd,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(CLK_PER_BIT);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
        StParity = 3'd3,
`endif
        StStop   = 3'd4
    } state_e;

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    logic [7:0]    head;

    // Serializer state
    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          tick;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    assign tready = (count_q != CW'(DEPTH));
    assign push   = tvalid && tready;
    assign head   = mem_q[rd_ptr_q];
    assign tick   = (timer_q == TW'(CLK_PER_BIT - 1));

    assign count_d = count_q + CW'(push) - CW'(pop);

    // Storage is not reset: the pointers and count already define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Next-state logic. txd_d is the line level for the state being entered,
    // so the registered txd changes on the same edge as the state.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        unique case (state_q)
            StIdle: begin
                txd_d   = 1'b1;
                timer_d = '0;
                if (count_q != '0) begin
                    pop      = 1'b1;
                    shift_d  = head;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                    state_d  = StStart;
                    txd_d    = 1'b0;
                end
            end

            StStart: begin
                if (tick) begin
                    timer_d = '0;
                    bit_d   = '0;
                    state_d = StData;
                    txd_d   = shift_q[0];
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            StData: begin
                if (tick) begin
                    timer_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
                        txd_d   = parity_q;
`else
                        state_d = StStop;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (tick) begin
                    timer_d = '0;
                    state_d = StStop;
                    txd_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`endif

            StStop: begin
                if (tick) begin
                    timer_d = '0;
                    if (count_q != '0) begin
                        // Back-to-back: next start bit follows the stop bit directly.
                        pop      = 1'b1;
                        shift_d  = head;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^head;
`endif
                        state_d  = StStart;
                        txd_d    = 1'b0;
                    end else begin
                        state_d = StIdle;
                        txd_d   = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: begin
                state_d = StIdle;
                timer_d = '0;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign txd   = txd_q;
    assign count = count_q;
    assign busy  = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// Testbench for uart_tx_fifo (CLK_PER_BIT=4, DEPTH=4).
// A queue-based frame model predicts txd/busy/count/tready every cycle. A few
// literal expectations pin the model itself.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 44;
`else
    localparam int FL = 40;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] tdata = 8'h00;
    logic       tvalid = 1'b0;
    logic       tready, txd, busy;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_PER_BIT(CPB),
        .DEPTH      (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tdata (tdata),
        .tvalid(tvalid),
        .tready(tready),
        .txd   (txd),
        .busy  (busy),
        .count (count)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: queue of pending bytes plus position inside the current frame.
    logic [7:0] mq[$];
    logic [7:0] m_byte = 8'h00;
    int         m_pos = -1;
    bit         m_push, m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pos = -1;
        end else begin
            m_push = tvalid && (mq.size() < int'(DEPTH));
            m_pop  = (mq.size() > 0) && (m_pos < 0 || m_pos == FL - 1);
            if (m_pos >= 0) begin
                m_pos++;
                if (m_pos == FL) m_pos = -1;
            end
            if (m_pop) begin
                m_byte = mq.pop_front();
                m_pos  = 0;
            end
            if (m_push) mq.push_back(tdata);
        end
    end

    function automatic int exp_txd();
        int b;
        if (m_pos < 0) return 1;
        b = m_pos / int'(CPB);
        if (b == 0) return 0;
        if (b <= 8) return int'(m_byte[b-1]);
`ifdef UART_TX_PARITY_EN
        if (b == 9) return int'(^m_byte);
`endif
        return 1;
    endfunction

    always @(negedge clk) begin
        chk("txd",    int'(txd),    exp_txd());
        chk("busy",   int'(busy),   int'(m_pos >= 0 || mq.size() != 0));
        chk("count",  int'(count),  mq.size());
        chk("tready", int'(tready), int'(mq.size() != int'(DEPTH)));
    end

    // Called right after a negedge; returns at the negedge following acceptance.
    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        tdata  = b;
        tvalid = 1'b1;
        while (tready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("push_timeout", int'(n < 1000), 1);
        @(negedge clk);
        tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(n < 1000), 1);
        repeat (3) @(negedge clk);
    endtask

    // Sends one byte from idle, checks the 10th bit slot and where busy falls.
    task automatic send_check(input logic [7:0] b, input int exp_bit9);
        int n = 0;
        push_byte(b);
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 38) chk("bit9", int'(txd), exp_bit9);
        end
        chk("frame_len", n, FL + 1);
        repeat (2) @(negedge clk);
    endtask

    int a5_bits [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1,
`ifdef UART_TX_PARITY_EN
                         0,
`else
                         1,
`endif
                         1};

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txd",    int'(txd),    1);
        chk("rst_tready", int'(tready), 1);
        chk("rst_busy",   int'(busy),   0);
        chk("rst_count",  int'(count),  0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_txd", int'(txd), 1);
        end

        // Single byte 0xA5: start at cycle 1, busy falls at FL+1.
        push_byte(8'hA5);
        for (int c = 0; c <= FL + 4; c++) begin
            chk("a5_txd", int'(txd), (c == 0 || c > FL) ? 1 : a5_bits[(c - 1) / 4]);
            chk("a5_busy", int'(busy), int'(c <= FL));
            @(negedge clk);
        end
        wait_idle();

`ifdef UART_TX_PARITY_EN
        send_check(8'h07, 1);
        send_check(8'h03, 0);
`else
        send_check(8'h07, 1);
        send_check(8'h03, 1);
`endif
        wait_idle();

        // Burst with tvalid held: FIFO fills after the fifth push.
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h55);
        push_byte(8'h3C);
        push_byte(8'h81);
        chk("burst_count",  int'(count),  4);
        chk("burst_tready", int'(tready), 0);
        push_byte(8'h99);
        wait_idle();

        // Push coinciding with the back-to-back pop at count=2.
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        chk("simul_pre_count", int'(count), 2);
        repeat (FL - 2) @(negedge clk);
        push_byte(8'h44);
        chk("simul_count", int'(count), 2);
        wait_idle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            tvalid = ($urandom_range(0, 9) == 0);
            tdata  = 8'($urandom);
            @(negedge clk);
        end
        tvalid = 1'b0;
        wait_idle();

        // Reset during bit 3 of 0x0F with two bytes queued.
        push_byte(8'h0F);
        push_byte(8'hC3);
        push_byte(8'h5A);
        repeat (16) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_txd",    int'(txd),    1);
        chk("mrst_count",  int'(count),  0);
        chk("mrst_busy",   int'(busy),   0);
        chk("mrst_tready", int'(tready), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("post_rst_txd",  int'(txd),  1);
            chk("post_rst_busy", int'(busy), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
